// File: rtl/asc_uart_tx.sv
// 8N1 UART sender for an 8-char ASCII hex string, MS char first.
// Define ASC_UART_TX_CRLF_EN to append CR, LF after the string.
module asc_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] asc_code,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        txd
);

`ifdef ASC_UART_TX_CRLF_EN
  localparam int NCHARS = 10;
`else
  localparam int NCHARS = 8;
`endif

  localparam int HOLD_W = NCHARS * 8;
  localparam int CNT_W  = (CLKS_PER_BIT > 2) ?
                          $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = $clog2(NCHARS);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] CHR_LAST =
    IDX_W'(NCHARS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [IDX_W-1:0]   chr_q, chr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               done_q, done_d;

  logic               wrap;
  logic [7:0]         cur_chr;
  logic [HOLD_W-1:0]  load_val;

`ifdef ASC_UART_TX_CRLF_EN
  assign load_val = {asc_code, 8'h0D, 8'h0A};
`else
  assign load_val = asc_code;
`endif

  assign wrap    = (cnt_q == CNT_MAX);
  assign cur_chr = hold_q[HOLD_W-1 -: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      chr_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      chr_q   <= chr_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    chr_d   = chr_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          hold_d  = load_val;
          chr_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (wrap) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (wrap) begin
          if (chr_q == CHR_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            chr_d   = chr_q + 1'b1;
            hold_d  = hold_q << 8;
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level decodes straight from state so launch is zero-latency.
  always_comb begin
    txd = 1'b1;
    unique case (state_q)
      S_IDLE:  txd = 1'b1;
      S_START: txd = 1'b0;
      S_DATA:  txd = cur_chr[bit_q];
      S_STOP:  txd = 1'b1;
      default: txd = 1'b1;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_asc_uart_tx.sv
// Directed self-checking bench for asc_uart_tx.
// Uses CLKS_PER_BIT=4; frame = 40 cycles.
module tb_asc_uart_tx;

`ifdef ASC_UART_TX_CRLF_EN
  localparam int NCH = 10;
`else
  localparam int NCH = 8;
`endif
  localparam int CPB   = 4;
  localparam int TOTAL = NCH * 10 * CPB;

  logic        clk;
  logic        rst;
  logic [63:0] asc_code;
  logic        start;
  logic        busy;
  logic        done;
  logic        txd;

  int checks;
  int failures;

  asc_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .asc_code (asc_code),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .txd      (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h",
               tag, obs, exp);
    end
  endtask

  // Expected {txd,busy,done} t cycles after launch edge.
  function automatic logic [2:0] model(
    input logic [63:0] code,
    input int          t
  );
    logic [79:0] s;
    logic [7:0]  ch;
    int          c;
    int          b;
    logic        bitv;
    s = {code, 8'h0D, 8'h0A};
    if (t < TOTAL) begin
      c  = t / (10 * CPB);
      b  = (t % (10 * CPB)) / CPB;
      ch = 8'(s >> (72 - 8 * c));
      if (b == 0)      bitv = 1'b0;
      else if (b == 9) bitv = 1'b1;
      else             bitv = ch[b-1];
      return {bitv, 1'b1, 1'b0};
    end
    if (t == TOTAL) return 3'b101;
    return 3'b100;
  endfunction

  task automatic sample(
    input string      tag,
    input logic [2:0] e
  );
    chk({tag, ".txd"},  64'(txd),  64'(e[2]));
    chk({tag, ".busy"}, 64'(busy), 64'(e[1]));
    chk({tag, ".done"}, 64'(done), 64'(e[0]));
  endtask

  // Launch one string; optional ignored start at t=50,
  // optional reset raised after edge abort_at.
  task automatic send(
    input string       tag,
    input logic [63:0] code,
    input bit          poke,
    input int          abort_at
  );
    bit aborted;
    aborted  = 1'b0;
    asc_code = code;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int t = 0; t <= TOTAL + 1; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      if (aborted) begin
        rst = 1'b0;
        sample(tag, 3'b100);
      end else begin
        sample(tag, model(code, t));
      end
      if (poke && t == 50) begin
        start    = 1'b1;
        asc_code = 64'h3030303030303030;
      end
      if (poke && t == 51) start = 1'b0;
      if (t == abort_at) begin
        rst     = 1'b1;
        aborted = 1'b1;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b1;
    asc_code = 64'h3132333441424344;

    // Reset with start held high.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      sample("rst", 3'b100);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    sample("post_rst", 3'b100);

    // Single string, then ignored start mid-string.
    send("single", 64'h3132333441424344, 1'b0, -1);
    send("ignore", 64'h3132333441424344, 1'b1, -1);

    // Mid-frame reset, then a full clean string.
    send("abort", 64'h3132333441424344, 1'b0, 100);
    send("recover", 64'h3132333441424344, 1'b0, -1);

    // Back-to-back strings with start held high.
    asc_code = 64'h4646464646464646;
    start    = 1'b1;
    @(posedge clk);
    #1;
    for (int t = 0; t <= 2 * TOTAL + 2; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      if (t <= TOTAL) begin
        sample("b2b1", model(asc_code, t));
      end else begin
        sample("b2b2", model(asc_code, t - TOTAL - 1));
      end
      if (t == 2 * TOTAL + 1) start = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/asc_uart_tx.md
Name: asc_uart_tx

Overview:
- Serial text sender for the CPU debug path. It consumes the 64-bit, 8-character ASCII hex string produced by the 32-bit binary-to-ASCII converter.
- It transmits the characters over an 8N1 UART line, most significant character first, so that a host terminal can log register and PC values.
- Sits between the hex-ASCII converter and the board's UART TX pin.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range is 2 or more.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- asc_code  input  64  eight ASCII characters; [63:56] is sent first, [7:0] last.
- start  input  1  request to send; sampled only when busy=0.
- busy  output  1  high while a string is being transmitted.
- done  output  1  one-cycle pulse when the last stop bit completes.
- txd  output  1  UART serial out; idles high.

Behaviour:
- Reset (rst=1 at a rising edge): next cycle txd=1, busy=0, done=0. The FSM goes to IDLE and the baud counter, bit index and char index clear to 0. Reset mid-frame aborts immediately; there is no completion and no done pulse.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: txd=1. On an edge with start=1:
  - latch asc_code into a 64-bit shift/hold register;
  - char index = 0; go to START;
  - busy=1 and txd=0 are visible right after that edge (zero-cycle launch latency).
- START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: txd = current char bit[bit index], LSB first. Each bit is held CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. Then:
  - if this was not the last character: increment char index and go to START. There is no idle gap between characters.
  - if it was the last character: go to IDLE, drop busy, and pulse done for exactly one cycle.
- Timing: one frame = 10*CLKS_PER_BIT cycles; one string = N*10*CLKS_PER_BIT cycles, where N=8 (or 10 with the optional feature).
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs at wrap. The counter width is clog2(CLKS_PER_BIT).
- start while busy=1 is ignored, not queued.
- asc_code changes while busy have no effect; only the latched copy is sent.
- start asserted in the same cycle as done: accepted only on the following edge, because the FSM is in IDLE only from that edge on. done and the new busy never overlap.
- start held high continuously: strings are sent back to back with exactly one idle-high cycle between them.
- Character bytes are not validated; any 8-bit value is sent verbatim.

Optional Feature:
- Macro: ASC_UART_TX_CRLF_EN.
- Defined: after the 8 characters, two more frames are appended, 0x0D then 0x0A. N=10, and done fires after the LF stop bit.
- Undefined: exactly 8 frames are sent; no terminator logic is synthesized.

Test Plan:
All tests use CLKS_PER_BIT=4 and the macro undefined unless stated.
1. Reset: hold rst for 3 cycles, with start=1 during reset → txd=1, busy=0, done=0 throughout; no frame starts until rst=0 and start=1.
2. Single string: asc_code=0x3132333441424344 ("1234ABCD"), pulse start at edge k → the decoded serial bytes are 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44; each bit lasts 4 cycles; busy is high on edges k..k+319; done is high for one cycle after edge k+320.
3. Ignored start: during test 2, pulse start at k+50 and change asc_code to 0x3030303030303030 → the output is still "1234ABCD"; exactly one done pulse.
4. Mid-frame reset: assert rst at k+100 (inside char 3) → txd=1 and busy=0 on the next cycle; no done pulse; a new start then sends a full, correct 8-char string.
5. Back-to-back: start held high with asc_code=0x4646464646464646 → two consecutive "FFFFFFFF" strings separated by exactly one idle-high cycle; two done pulses, 321 cycles apart.
6. CRLF (macro defined): send "1234ABCD" → 10 frames ending in 0x0D, 0x0A; done is high for one cycle after edge k+400.
